// File: rtl/led_status_tx_pkg.sv
// Shared frame constants, state encoding and helpers for the LED status
// reply path. The receive-side LED command path imports the same constants
// for its 'n' and index checks.
package led_status_tx_pkg;

   // ASCII characters that make up an "LED on N" / "LED of N" frame.
   localparam logic [7:0] ASCII_L    = 8'h4C;
   localparam logic [7:0] ASCII_E    = 8'h45;
   localparam logic [7:0] ASCII_D    = 8'h44;
   localparam logic [7:0] ASCII_SP   = 8'h20;
   localparam logic [7:0] ASCII_O    = 8'h6F;
   localparam logic [7:0] ASCII_N    = 8'h6E;
   localparam logic [7:0] ASCII_F    = 8'h66;
   localparam logic [7:0] ASCII_ZERO = 8'h30;

   // Frame geometry: eight bytes, byte_pos is a 3-bit counter.
   localparam int         FRAME_LEN = 8;
   localparam logic [2:0] LAST_POS  = 3'(FRAME_LEN - 1);

   // Default LED count and the "report every LED" request index.
   localparam int         NUM_LEDS_DEF = 10;
   localparam logic [3:0] ALL_IDX_DEF  = 4'hF;

   // Transmit FSM states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_NEXT = 2'd2
   } tx_state_e;

   // ASCII digit for an LED index (only 0..9 are ever sent).
   function automatic logic [7:0] idx_char(input logic [3:0] idx);
      return ASCII_ZERO + {4'h0, idx};
   endfunction

endpackage

// File: rtl/led_status_tx_frame_byte.sv
// Combinational byte select for one status frame: given the position within
// the frame, the LED index and its snapshot bit, produce the ASCII byte.
module led_frame_byte
   import led_status_tx_pkg::*;
(
   input  logic [2:0] byte_pos_i,
   input  logic [3:0] idx_i,
   input  logic       on_bit_i,
   output logic [7:0] byte_o
);

   // Map frame position to its character; byte 5 is on/off, byte 7 the index.
   always_comb begin
      byte_o = 8'h00;
      case (byte_pos_i)
         3'd0: byte_o = ASCII_L;
         3'd1: byte_o = ASCII_E;
         3'd2: byte_o = ASCII_D;
         3'd3: byte_o = ASCII_SP;
         3'd4: byte_o = ASCII_O;
         3'd5: byte_o = on_bit_i ? ASCII_N : ASCII_F;
         3'd6: byte_o = ASCII_SP;
         3'd7: byte_o = idx_char(idx_i);
      endcase
   end

endmodule

// File: rtl/led_status_tx.sv
// LED status transmitter: on request, snapshots the LED bank and serialises
// one frame (single LED) or ten frames (all LEDs) to the UART TX.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. req_valid/req_ready: the request is taken only in IDLE (where
// req_ready=1); the requester holds req_valid otherwise. tx_valid/tx_data:
// once tx_valid is raised, tx_data and tx_valid stay unchanged until the edge
// on which tx_ready is also high; tx_ready has no effect while tx_valid=0.
module led_status_tx
   import led_status_tx_pkg::*;
#(
   parameter int         NUM_LEDS = NUM_LEDS_DEF,
   parameter logic [3:0] ALL_IDX  = ALL_IDX_DEF
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_LEDS-1:0] led_state,
   input  logic                req_valid,
   input  logic [3:0]          req_idx,
   output logic                req_ready,
   output logic                req_err,
   output logic [7:0]          tx_data,
   output logic                tx_valid,
   input  logic                tx_ready,
   output logic                busy
);

   localparam logic [3:0] IDX_LIMIT = 4'(NUM_LEDS);
   localparam logic [3:0] IDX_LAST  = 4'(NUM_LEDS - 1);

   tx_state_e             state_q, state_d;
   logic [2:0]            pos_q, pos_d;
   logic [3:0]            idx_q, idx_d;
   logic                  all_q, all_d;
   logic [NUM_LEDS-1:0]   snap_q, snap_d;

   logic [7:0]            tx_data_q, tx_data_d;
   logic                  tx_valid_q, tx_valid_d;
   logic                  req_ready_q, req_ready_d;
   logic                  req_err_q, req_err_d;
   logic                  busy_q, busy_d;

   logic                  on_bit;
   logic [7:0]            frame_byte;
   logic                  tx_fire;

   assign tx_fire = tx_valid_q & tx_ready;

   // Next-state logic: request accept, byte stepping and frame sequencing.
   always_comb begin
      state_d   = state_q;
      pos_d     = pos_q;
      idx_d     = idx_q;
      all_d     = all_q;
      snap_d    = snap_q;
      req_err_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               if (req_idx == ALL_IDX) begin
                  snap_d  = led_state;
                  all_d   = 1'b1;
                  idx_d   = 4'd0;
                  pos_d   = 3'd0;
                  state_d = ST_SEND;
               end else if (req_idx < IDX_LIMIT) begin
                  snap_d  = led_state;
                  all_d   = 1'b0;
                  idx_d   = req_idx;
                  pos_d   = 3'd0;
                  state_d = ST_SEND;
               end else begin
                  // Out-of-range index: drop the request and flag it.
                  req_err_d = 1'b1;
               end
            end
         end
         ST_SEND: begin
            if (tx_fire) begin
               // Wraps 7->0 naturally on the last byte of a frame.
               pos_d = pos_q + 3'd1;
               if (pos_q == LAST_POS) begin
                  if (all_q && (idx_q != IDX_LAST)) begin
                     state_d = ST_NEXT;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end
         end
         ST_NEXT: begin
            idx_d   = idx_q + 4'd1;
            pos_d   = 3'd0;
            state_d = ST_SEND;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Snapshot bit for the LED whose frame will be on the wire next cycle.
   always_comb begin
      on_bit = 1'b0;
      for (int i = 0; i < NUM_LEDS; i++) begin
         if (idx_d == 4'(i)) begin
            on_bit = snap_d[i];
         end
      end
   end

   led_frame_byte u_frame_byte (
      .byte_pos_i (pos_d),
      .idx_i      (idx_d),
      .on_bit_i   (on_bit),
      .byte_o     (frame_byte)
   );

   // Registered outputs derived from the next state, so every port is a flop.
   always_comb begin
      tx_valid_d  = (state_d == ST_SEND);
      tx_data_d   = tx_valid_d ? frame_byte : 8'h00;
      busy_d      = (state_d != ST_IDLE);
      req_ready_d = (state_d == ST_IDLE);
   end

   // State and output registers with synchronous reset; reset abandons a frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         pos_q       <= 3'd0;
         idx_q       <= 4'd0;
         all_q       <= 1'b0;
         snap_q      <= '0;
         tx_data_q   <= 8'h00;
         tx_valid_q  <= 1'b0;
         req_ready_q <= 1'b1;
         req_err_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pos_q       <= pos_d;
         idx_q       <= idx_d;
         all_q       <= all_d;
         snap_q      <= snap_d;
         tx_data_q   <= tx_data_d;
         tx_valid_q  <= tx_valid_d;
         req_ready_q <= req_ready_d;
         req_err_q   <= req_err_d;
         busy_q      <= busy_d;
      end
   end

   assign tx_data   = tx_data_q;
   assign tx_valid  = tx_valid_q;
   assign req_ready = req_ready_q;
   assign req_err   = req_err_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_led_status_tx.sv
// Directed bench for led_status_tx: single frames, stalled frames, all-LED
// sweep with a mid-sweep LED change, bad index, and reset mid-frame.
module tb_led_status_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] led_state = 10'h000;
   logic       req_valid = 1'b0;
   logic [3:0] req_idx = 4'h0;
   logic       tx_ready = 1'b0;
   logic       req_ready;
   logic       req_err;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       busy;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];

   // Clock
   always #5 clk = ~clk;

   led_status_tx #(
      .NUM_LEDS (10),
      .ALL_IDX  (4'hF)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .led_state (led_state),
      .req_valid (req_valid),
      .req_idx   (req_idx),
      .req_ready (req_ready),
      .req_err   (req_err),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Expected bytes of one frame, from hand-written ASCII values.
   task automatic push_frame(input logic [3:0] idx, input logic on);
      exp_q.push_back(8'h4C);
      exp_q.push_back(8'h45);
      exp_q.push_back(8'h44);
      exp_q.push_back(8'h20);
      exp_q.push_back(8'h6F);
      exp_q.push_back(on ? 8'h6E : 8'h66);
      exp_q.push_back(8'h20);
      exp_q.push_back(8'h30 + {4'h0, idx});
   endtask

   // Present a request for exactly one accept edge.
   task automatic issue(input logic [3:0] idx);
      @(negedge clk);
      req_valid = 1'b1;
      req_idx   = idx;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   // Consume bytes against exp_q; optionally toggle tx_ready to force stalls.
   task automatic drain(input bit toggle, input int exp_cycles, input int budget);
      int cyc = 0;
      bit stalled = 1'b0;
      logic [7:0] held = 8'h00;
      while (exp_q.size() > 0 && cyc < budget) begin
         @(negedge clk);
         tx_ready = toggle ? (cyc % 2 == 0) : 1'b1;
         if (stalled) begin
            check("hold_valid", tx_valid, 1);
            check("hold_data", tx_data, held);
         end
         if (tx_valid) begin
            check("busy_sending", busy, 1);
            check("ready_low", req_ready, 0);
            if (tx_ready) begin
               check("byte", tx_data, exp_q.pop_front());
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               held    = tx_data;
            end
         end else begin
            check("gap_busy", busy, 1);
            stalled = 1'b0;
         end
         cyc++;
      end
      check("bytes_left", exp_q.size(), 0);
      if (exp_cycles >= 0) check("cycles", cyc, exp_cycles);
      exp_q.delete();
      @(negedge clk);
      check("idle_valid", tx_valid, 0);
      check("idle_busy", busy, 0);
      check("idle_ready", req_ready, 1);
   endtask

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_valid", tx_valid, 0);
      check("rst_data", tx_data, 8'h00);
      check("rst_ready", req_ready, 1);
      check("rst_err", req_err, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;

      // Single frame, LED 2 on, full-rate
      led_state = 10'h004;
      tx_ready  = 1'b1;
      push_frame(4'd2, 1'b1);
      issue(4'd2);
      drain(1'b0, 8, 20);

      // Single frame, LED 7 off, tx_ready toggling
      led_state = 10'h000;
      push_frame(4'd7, 1'b0);
      issue(4'd7);
      drain(1'b1, -1, 40);

      // All LEDs, alternating pattern, LED bank changes mid-sweep
      led_state = 10'h155;
      tx_ready  = 1'b1;
      for (int i = 0; i < 10; i++) push_frame(4'(i), (i % 2) == 0);
      issue(4'hF);
      fork
         drain(1'b0, 89, 200);
         begin
            repeat (30) @(negedge clk);
            led_state = 10'h2AA;
         end
      join

      // Bad index
      issue(4'd12);
      @(negedge clk);
      check("err_pulse", req_err, 1);
      check("err_no_valid", tx_valid, 0);
      check("err_ready", req_ready, 1);
      check("err_busy", busy, 0);
      @(negedge clk);
      check("err_clear", req_err, 0);
      check("err_no_valid2", tx_valid, 0);
      // Following request served normally (LED 0 is off in 10'h2AA)
      push_frame(4'd0, 1'b0);
      issue(4'd0);
      drain(1'b0, 8, 20);

      // Reset mid-frame, then a fresh request for LED 9
      led_state = 10'h3FF;
      tx_ready  = 1'b1;
      issue(4'd5);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_valid", tx_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ready", req_ready, 1);
      check("mid_rst_data", tx_data, 8'h00);
      rst = 1'b0;
      led_state = 10'h200;
      push_frame(4'd9, 1'b1);
      issue(4'd9);
      drain(1'b0, 8, 20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
